// File: rtl/cplx_expand_sched.sv
// ---------------------------------------------------------------------------
// cplx_expand_sched
//   Frame-level scheduler that time-shares one complex sign-expansion datapath
//   between two complex sample sources. A source is granted the datapath for a
//   whole frame of FRAME_LEN samples; grants alternate round-robin. The
//   expanded sample is registered behind a valid/ready output with frame
//   markers and a source tag.
//
// Ports
//   clk, rst_n             : clock (rising edge), async active-low reset
//   s0_valid/ready/re/im   : source 0 sample stream (IWIDTH two's complement)
//   s1_valid/ready/re/im   : source 1 sample stream
//   m_valid, m_ready       : output handshake
//   m_re, m_im             : expanded sample (OWIDTH)
//   m_src                  : source index of the output sample
//   m_sof, m_eof           : first / last sample of a frame
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// signed_cplx_expand
//   Widens each complex component from IWIDTH to OWIDTH by sign extension,
//   then shifts left by IPRE bits (input carries IPRE fewer fractional bits
//   than the output format). With IPRE = 0 this is plain sign extension.
//   Requires OWIDTH >= IWIDTH + IPRE so nothing is lost.
//
// Ports
//   i_re, i_im : input components (IWIDTH, signed)
//   o_re, o_im : expanded components (OWIDTH, signed)
// ---------------------------------------------------------------------------
module signed_cplx_expand #(
  parameter int IWIDTH = 16,
  parameter int OWIDTH = 16,
  parameter int IPRE   = 0
) (
  input  logic signed [IWIDTH-1:0] i_re,
  input  logic signed [IWIDTH-1:0] i_im,
  output logic signed [OWIDTH-1:0] o_re,
  output logic signed [OWIDTH-1:0] o_im
);

  logic signed [IWIDTH-1:0] comp_in  [2];
  logic signed [OWIDTH-1:0] comp_out [2];

  assign comp_in[0] = i_re;
  assign comp_in[1] = i_im;

  // Same mapping on both components.
  for (genvar gi = 0; gi < 2; gi++) begin : g_comp
    logic signed [OWIDTH-1:0] ext;
    assign ext          = OWIDTH'(comp_in[gi]);  // signed operand: sign-extends
    assign comp_out[gi] = ext <<< IPRE;
  end

  assign o_re = comp_out[0];
  assign o_im = comp_out[1];

endmodule

module cplx_expand_sched #(
  parameter int IWIDTH    = 16,
  parameter int OWIDTH    = 16,
  parameter int IPRE      = 0,
  parameter int FRAME_LEN = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s0_valid,
  output logic              s0_ready,
  input  logic [IWIDTH-1:0] s0_re,
  input  logic [IWIDTH-1:0] s0_im,
  input  logic              s1_valid,
  output logic              s1_ready,
  input  logic [IWIDTH-1:0] s1_re,
  input  logic [IWIDTH-1:0] s1_im,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [OWIDTH-1:0] m_re,
  output logic [OWIDTH-1:0] m_im,
  output logic              m_src,
  output logic              m_sof,
  output logic              m_eof
);

  localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  state_t          state_reg, state_next;
  logic            prio_reg, prio_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            m_valid_reg, m_valid_next;
  logic [OWIDTH-1:0] m_re_reg, m_im_reg;
  logic            m_src_reg, m_sof_reg, m_eof_reg;

  logic            out_free;
  logic            grant_sel;
  logic            cnt_last;
  logic            accept;
  logic [IWIDTH-1:0] sel_re, sel_im;
  logic signed [OWIDTH-1:0] exp_re, exp_im;

  // The output register can take a new sample when empty or being drained.
  assign out_free  = !m_valid_reg || m_ready;
  assign grant_sel = (state_reg == GRANT1);
  assign cnt_last  = (cnt_reg == CW'(FRAME_LEN - 1));

  assign sel_re = grant_sel ? s1_re : s0_re;
  assign sel_im = grant_sel ? s1_im : s0_im;

  signed_cplx_expand #(
    .IWIDTH (IWIDTH),
    .OWIDTH (OWIDTH),
    .IPRE   (IPRE)
  ) u_expand (
    .i_re (sel_re),
    .i_im (sel_im),
    .o_re (exp_re),
    .o_im (exp_im)
  );

  always_comb begin
    state_next   = state_reg;
    prio_next    = prio_reg;
    cnt_next     = cnt_reg;
    s0_ready     = 1'b0;
    s1_ready     = 1'b0;
    accept       = 1'b0;
    m_valid_next = m_valid_reg;

    // Readies depend only on state and the output handshake, never on valid.
    unique case (state_reg)
      IDLE: begin
        if (s0_valid && s1_valid) state_next = prio_reg ? GRANT1 : GRANT0;
        else if (s0_valid)        state_next = GRANT0;
        else if (s1_valid)        state_next = GRANT1;
      end
      GRANT0:  s0_ready = out_free;
      GRANT1:  s1_ready = out_free;
      default: state_next = IDLE;
    endcase

    accept = (s0_ready && s0_valid) || (s1_ready && s1_valid);

    // Grant is held for the whole frame; only the last sample releases it.
    if (accept) begin
      if (cnt_last) begin
        cnt_next   = '0;
        state_next = IDLE;
        prio_next  = !grant_sel;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end

    if (accept)       m_valid_next = 1'b1;
    else if (m_ready) m_valid_next = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      prio_reg    <= 1'b0;
      cnt_reg     <= '0;
      m_valid_reg <= 1'b0;
      m_re_reg    <= '0;
      m_im_reg    <= '0;
      m_src_reg   <= 1'b0;
      m_sof_reg   <= 1'b0;
      m_eof_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      prio_reg    <= prio_next;
      cnt_reg     <= cnt_next;
      m_valid_reg <= m_valid_next;
      if (accept) begin
        m_re_reg  <= exp_re;
        m_im_reg  <= exp_im;
        m_src_reg <= grant_sel;
        m_sof_reg <= (cnt_reg == '0);
        m_eof_reg <= cnt_last;
      end
    end
  end

  assign m_valid = m_valid_reg;
  assign m_re    = m_re_reg;
  assign m_im    = m_im_reg;
  assign m_src   = m_src_reg;
  assign m_sof   = m_sof_reg;
  assign m_eof   = m_eof_reg;

endmodule

// File: tb/tb_cplx_expand_sched.sv
// ---------------------------------------------------------------------------
// tb_cplx_expand_sched
//   Directed-vector bench with a scoreboard. Stimulus tasks queue samples per
//   source and push the expected output (in expected arrival order) into a
//   scoreboard queue; an independent monitor pops and compares every output
//   transfer. Directed checks cover reset values, arbitration timing,
//   backpressure, grant holding across gaps and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_cplx_expand_sched;

  localparam int IW = 8;
  localparam int OW = 16;
  localparam int FL = 4;

  typedef struct packed {
    logic          src;
    logic          sof;
    logic          eof;
    logic [OW-1:0] re;
    logic [OW-1:0] im;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s0_valid, s0_ready, s1_valid, s1_ready;
  logic [IW-1:0] s0_re, s0_im, s1_re, s1_im;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [OW-1:0] m_re, m_im;
  logic          m_src, m_sof, m_eof;

  exp_t              expq[$];
  logic [2*IW-1:0]   q0[$];
  logic [2*IW-1:0]   q1[$];
  bit                gap0 = 1'b0;

  int n_cmp = 0;
  int n_fail = 0;
  int out_cnt = 0;
  int cyc = 0;
  int first_cyc = 0;
  int last_cyc = 0;

  cplx_expand_sched #(
    .IWIDTH    (IW),
    .OWIDTH    (OW),
    .IPRE      (0),
    .FRAME_LEN (FL)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s0_valid (s0_valid),
    .s0_ready (s0_ready),
    .s0_re    (s0_re),
    .s0_im    (s0_im),
    .s1_valid (s1_valid),
    .s1_ready (s1_ready),
    .s1_re    (s1_re),
    .s1_im    (s1_im),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_re     (m_re),
    .m_im     (m_im),
    .m_src    (m_src),
    .m_sof    (m_sof),
    .m_eof    (m_eof)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, want, $time);
    end
  endtask

  function automatic logic [OW-1:0] sx8(input logic [IW-1:0] v);
    return {{(OW-IW){v[IW-1]}}, v};
  endfunction

  // Queue one sample on a source; optionally record its expected output.
  task automatic send(input bit src, input int k, input logic [IW-1:0] re,
                      input logic [IW-1:0] im, input logic [OW-1:0] ere,
                      input logic [OW-1:0] eim, input bit add_exp);
    exp_t e;
    if (src) q1.push_back({re, im});
    else     q0.push_back({re, im});
    if (add_exp) begin
      e.src = src;
      e.sof = (k == 0);
      e.eof = (k == FL - 1);
      e.re  = ere;
      e.im  = eim;
      expq.push_back(e);
    end
  endtask

  task automatic sendx(input bit src, input int k, input logic [IW-1:0] re,
                       input logic [IW-1:0] im);
    send(src, k, re, im, sx8(re), sx8(im), 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_m_valid"}, 64'(m_valid), 64'd0);
    check({tag, "_m_re_im"}, 64'({m_re, m_im}), 64'd0);
    check({tag, "_m_flags"}, 64'({m_src, m_sof, m_eof}), 64'd0);
    check({tag, "_readies"}, 64'({s0_ready, s1_ready}), 64'd0);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || expq.size() != 0 || m_valid) && n < 200) begin
      @(negedge clk); #2;
      n++;
    end
    check({tag, "_drain_timeout"}, 64'(n >= 200), 64'd0);
    q0.delete(); q1.delete(); expq.delete();
  endtask

  // Source drivers: a transfer seen at the negedge pops its sample after the edge.
  initial begin
    bit f0, f1;
    s0_valid = 1'b0; s1_valid = 1'b0;
    s0_re = '0; s0_im = '0; s1_re = '0; s1_im = '0;
    forever begin
      @(negedge clk);
      f0 = s0_valid && s0_ready;
      f1 = s1_valid && s1_ready;
      @(posedge clk); #1;
      if (f0 && q0.size() > 0) void'(q0.pop_front());
      if (f1 && q1.size() > 0) void'(q1.pop_front());
      s0_valid = (q0.size() > 0) && !gap0;
      s1_valid = (q1.size() > 0);
      if (q0.size() > 0) {s0_re, s0_im} = q0[0];
      if (q1.size() > 0) {s1_re, s1_im} = q1[0];
    end
  end

  // Monitor: compare every output transfer with the scoreboard head.
  initial begin
    exp_t e, got;
    forever begin
      @(negedge clk);
      if (rst_n && m_valid && m_ready) begin
        got = {m_src, m_sof, m_eof, m_re, m_im};
        $display("out src=%0d sof=%0d eof=%0d re=%h im=%h", m_src, m_sof, m_eof, m_re, m_im);
        if (expq.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL out_unexpected: got %h, required no output", got);
        end else begin
          e = expq.pop_front();
          check("out_sample", 64'(got), 64'(e));
          if (out_cnt == 0) first_cyc = cyc;
          last_cyc = cyc;
          out_cnt++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int gap_state;

    // Reset values.
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("rst0");
    rst_n = 1'b1;

    // Test 1: single source, boundary values, IDLE arbitration cycle.
    @(negedge clk); #1;
    out_cnt = 0;
    send(0, 0, 8'h7F, 8'h81, 16'h007F, 16'hFF81, 1'b1);
    send(0, 1, 8'h80, 8'h80, 16'hFF80, 16'hFF80, 1'b1);
    send(0, 2, 8'h01, 8'hFF, 16'h0001, 16'hFFFF, 1'b1);
    send(0, 3, 8'hFF, 8'h01, 16'hFFFF, 16'h0001, 1'b1);
    @(negedge clk); #1;
    check("t1_idle_s0_ready", 64'(s0_ready), 64'd0);
    check("t1_idle_s0_valid", 64'(s0_valid), 64'd1);
    @(negedge clk); #1;
    check("t1_grant_s0_ready", 64'(s0_ready), 64'd1);
    check("t1_grant_s1_ready", 64'(s1_ready), 64'd0);
    drain("t1");
    check("t1_out_count", 64'(out_cnt), 64'd4);

    // Reset pulse clears prio so the alternation test starts with source 0.
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst1");
    @(negedge clk); #1;
    rst_n = 1'b1;

    // Test 2: both sources continuously valid; frames alternate.
    @(negedge clk); #1;
    out_cnt = 0;
    sendx(0, 0, 8'h11, 8'h91); sendx(0, 1, 8'h22, 8'hA2);
    sendx(0, 2, 8'h33, 8'hB3); sendx(0, 3, 8'h44, 8'hC4);
    sendx(1, 0, 8'h85, 8'h01); sendx(1, 1, 8'h06, 8'h02);
    sendx(1, 2, 8'hF7, 8'h03); sendx(1, 3, 8'h08, 8'h04);
    sendx(0, 0, 8'h55, 8'h10); sendx(0, 1, 8'h66, 8'h20);
    sendx(0, 2, 8'h77, 8'h30); sendx(0, 3, 8'h88, 8'h40);
    sendx(1, 0, 8'h9A, 8'hE0); sendx(1, 1, 8'hBC, 8'hC0);
    sendx(1, 2, 8'hDE, 8'hA0); sendx(1, 3, 8'hF0, 8'h80);
    drain("t2");
    check("t2_out_count", 64'(out_cnt), 64'd16);
    // 4 frames of FL samples with one arbitration cycle between frames.
    check("t2_span_cycles", 64'(last_cyc - first_cyc), 64'(4 * (FL + 1) - 2));

    // Test 3: 3-cycle backpressure mid-frame.
    @(negedge clk); #1;
    out_cnt = 0;
    sendx(0, 0, 8'h10, 8'hF0); sendx(0, 1, 8'h20, 8'hE0);
    sendx(0, 2, 8'h30, 8'hD0); sendx(0, 3, 8'h40, 8'hC0);
    n = 0;
    while (out_cnt < 1 && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    check("t3_first_out_timeout", 64'(n >= 50), 64'd0);
    @(posedge clk); #2;
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("t3_stall_s0_ready", 64'(s0_ready), 64'd0);
      check("t3_stall_m_valid", 64'(m_valid), 64'd1);
      if (expq.size() > 0)
        check("t3_stall_hold", 64'({m_src, m_sof, m_eof, m_re, m_im}), 64'(expq[0]));
      else
        check("t3_stall_expq", 64'(expq.size()), 64'd1);
    end
    @(posedge clk); #2;
    m_ready = 1'b1;
    drain("t3");
    check("t3_out_count", 64'(out_cnt), 64'd4);

    // Test 4: s0 gap mid-frame while s1 waits; no preemption.
    @(negedge clk); #1;
    out_cnt = 0;
    sendx(0, 0, 8'h01, 8'h81); sendx(0, 1, 8'h02, 8'h82);
    sendx(0, 2, 8'h03, 8'h83); sendx(0, 3, 8'h04, 8'h84);
    @(negedge clk); #1;
    @(negedge clk); #1;
    check("t4_grant_s0_ready", 64'(s0_ready), 64'd1);
    sendx(1, 0, 8'h7E, 8'h00); sendx(1, 1, 8'h7D, 8'hFF);
    sendx(1, 2, 8'h7C, 8'h00); sendx(1, 3, 8'h7B, 8'hFF);
    gap_state = 0;
    n = 0;
    while (q0.size() > 0 && n < 60) begin
      @(negedge clk); #1;
      n++;
      check("t4_s1_ready_blocked", 64'(s1_ready), 64'd0);
      if (gap_state == 0 && q0.size() <= 2) begin
        gap0 = 1'b1;
        gap_state = 1;
      end else if (gap_state > 0 && gap_state < 3) begin
        gap_state++;
        if (gap_state == 3) gap0 = 1'b0;
      end
    end
    gap0 = 1'b0;
    check("t4_s0_timeout", 64'(n >= 60), 64'd0);
    drain("t4");
    check("t4_out_count", 64'(out_cnt), 64'd8);

    // Test 5: async reset mid-frame while prio points at source 1.
    @(negedge clk); #1;
    sendx(0, 0, 8'h0A, 8'h0A); sendx(0, 1, 8'h0B, 8'h0B);
    sendx(0, 2, 8'h0C, 8'h0C); sendx(0, 3, 8'h0D, 8'h0D);
    drain("t5a");
    @(negedge clk); #1;
    out_cnt = 0;
    sendx(1, 0, 8'hA1, 8'h11); sendx(1, 1, 8'hA2, 8'h12);
    send(1, 2, 8'hA3, 8'h13, 16'h0, 16'h0, 1'b0);
    send(1, 3, 8'hA4, 8'h14, 16'h0, 16'h0, 1'b0);
    for (int i = 0; i < FL; i++) send(0, i, 8'hE0, 8'hE0, 16'h0, 16'h0, 1'b0);
    n = 0;
    while (out_cnt < 2 && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    check("t5_pre_reset_timeout", 64'(n >= 50), 64'd0);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst2");
    q0.delete(); q1.delete(); expq.delete();
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("rst2_hold");
    out_cnt = 0;
    sendx(0, 0, 8'h31, 8'hC1); sendx(0, 1, 8'h32, 8'hC2);
    sendx(0, 2, 8'h33, 8'hC3); sendx(0, 3, 8'h34, 8'hC4);
    sendx(1, 0, 8'h41, 8'hD1); sendx(1, 1, 8'h42, 8'hD2);
    sendx(1, 2, 8'h43, 8'hD3); sendx(1, 3, 8'h44, 8'hD4);
    rst_n = 1'b1;
    drain("t5b");
    check("t5_out_count", 64'(out_cnt), 64'd8);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cplx_expand_sched.md
# cplx_expand_sched

Frame-level scheduler that time-shares one complex sign-expansion datapath (a `signed_cplx_expand` instance) between two complex sample sources feeding the FFT input. It grants the datapath to one source for a whole frame of `FRAME_LEN` samples, alternating round-robin between sources. It registers the expanded result behind a valid/ready output with frame markers and a source tag.

## Interface
- `IWIDTH`, 16, input real/imag width per source (two's complement)
- `OWIDTH`, 16, output real/imag width; `OWIDTH >= IWIDTH`
- `IPRE`, 0, passed unchanged to the `signed_cplx_expand` instance
- `FRAME_LEN`, 64, samples per granted frame; >= 2
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous active-low reset, one clock, reset is asynchronous and active-low
- `s0_valid` in 1: source 0 sample valid
- `s0_ready` out 1: source 0 sample accepted this cycle when high with `s0_valid`
- `s0_re`, `s0_im` in IWIDTH: source 0 sample
- `s1_valid`, `s1_ready`, `s1_re`, `s1_im`: same for source 1
- `m_valid` out 1: output sample valid
- `m_ready` in 1: downstream accepts output
- `m_re`, `m_im` out OWIDTH: expanded sample
- `m_src` out 1: source index of the output sample
- `m_sof` out 1: first sample of frame
- `m_eof` out 1: last sample of frame

## Operation
- States: IDLE, GRANT0, GRANT1. Round-robin pointer `prio` (0 = source 0 preferred).
- IDLE: no `sX_ready`. If exactly one `sX_valid`, go to GRANTx. If both, go to GRANT`prio`. If none, stay.
- GRANTx: `sx_ready = !m_valid || m_ready`; other source `ready = 0`. Each accepted sample increments frame counter `cnt` (width `$clog2(FRAME_LEN)`).
- Acceptance with `cnt == FRAME_LEN-1`: `cnt` <- 0, state <- IDLE, `prio` <- opposite of x. The grant is held for a full frame regardless of gaps in `sx_valid`; no preemption by the other source.
- Output register loads on every acceptance: `m_re/m_im` = expanded `sx_re/sx_im`, `m_src` = x, `m_sof` = (`cnt == 0`), `m_eof` = (`cnt == FRAME_LEN-1`), `m_valid` <- 1.
- `m_valid` clears when `m_ready` is high and no new acceptance occurs in the same cycle. With `m_valid && !m_ready`, the register and all `m_*` outputs hold stable.
- Arithmetic: expansion is purely the `signed_cplx_expand` mapping on each component. With `IPRE = 0`, output = input sign-extended to OWIDTH, with no rounding or saturation.
- Reset (any time, including mid-frame): state IDLE, `prio` 0, `cnt` 0, `m_valid` 0, `m_re`/`m_im` 0, `m_src`/`m_sof`/`m_eof` 0, both `sX_ready` 0. A partial frame is discarded, and the next frame restarts with `m_sof`.

## Timing
- Arbitration: 1 cycle in IDLE. `sX_ready` can first be high the cycle after IDLE sees `valid`.
- Latency: a sample accepted on edge N appears on `m_*` after edge N (1 cycle).
- Throughput: 1 sample/cycle within a frame while `m_ready` stays high. Each frame costs `FRAME_LEN` + 1 cycles minimum.
- Backpressure: `sX_ready` falls combinationally in the same cycle that `m_valid && !m_ready`. No sample is lost or duplicated.
- `sX_ready` depends combinationally only on state, `m_valid` and `m_ready`, never on `sX_valid`.

## Test plan
- Single source, `FRAME_LEN=4`, IWIDTH=8, OWIDTH=16, IPRE=0, s0 sends re = 0x7F, 0x80, 0x01, 0xFF, with im = the negated pattern. Required output re = 0x007F, 0xFF80, 0x0001, 0xFFFF, `m_sof` on sample 1, `m_eof` on sample 4, `m_src`=0, one IDLE cycle before `s0_ready`.
- Both sources valid continuously, `FRAME_LEN=4`. Frames must alternate s0, s1, s0, s1, with 4 samples each, `m_src` matching each frame, and 1 idle cycle between frames.
- `m_ready` low for 3 cycles mid-frame. `m_*` must hold constant, `s0_ready` must be 0 for those cycles, and the sample sequence must be unchanged with no loss or duplication.
- s0 drops `s0_valid` for 2 cycles mid-frame while s1 stays valid. s1 must never see `s1_ready` until s0's frame completes, and s1's frame follows next.
- Assert `rst_n` low asynchronously after sample 2 of a frame. All outputs must go to reset values immediately. After release, the next accepted sample carries `m_sof`=1, and with both sources valid, s0 is granted first.
